read_ecall_receiver: RTL and testbench

Inbound counterpart of the write-ecall byte streamer. It services a CPU read ecall by accepting bytes from an external host over the 8-bit Arduino parallel port, paced by an asynchronous strobe/ready handshake. Each byte is written into data memory at consecutive addresses, and completion is reported back to the CPU. It sits beside the CPU and `DataMemory` in `HW_Interface`. While a transfer is active it owns the memory port through the top-level mux.

---
 rtl/read_ecall_receiver_pkg.sv | 15 +
 rtl/read_ecall_receiver_sync_edge_detect.sv | 29 ++
 rtl/read_ecall_receiver.sv | 126 ++++++++++++
 tb/tb_read_ecall_receiver.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_ecall_receiver_pkg.sv
// Shared widths, store type and FSM state encoding
// for the read-ecall byte receiver.
package read_ecall_receiver_pkg;

  localparam int         BIT_WIDTH  = 32;
  localparam logic [3:0] STORE_BYTE = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/read_ecall_receiver_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level,
// with a one-cycle pulse on each synchronized rising edge.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;

endmodule

// File: rtl/read_ecall_receiver.sv
// Services a CPU read ecall: takes host bytes over a strobe/ready
// handshake and stores them at consecutive data-memory addresses.
module read_ecall_receiver
  import read_ecall_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_ecall,
  input  logic [BIT_WIDTH-1:0] read_ecall_address,
  input  logic [BIT_WIDTH-1:0] read_ecall_len,
  output logic                 read_ecall_finished,
  output logic [BIT_WIDTH-1:0] read_ecall_count,
  input  logic [7:0]           ext_data,
  input  logic                 ext_strobe,
  input  logic                 ext_eot,
  output logic                 ext_ready,
  output logic                 overrun,
  output logic                 mem_busy,
  output logic                 mem_write_en,
  output logic [BIT_WIDTH-1:0] mem_address,
  output logic [BIT_WIDTH-1:0] mem_data,
  output logic [3:0]           mem_storetype
);

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] count_q, count_d;
  logic [7:0]           byte_q, byte_d;
  logic                 overrun_q, overrun_d;

  logic strobe_rise;
  logic strobe_level_unused;
  logic eot_level;
  logic eot_rise_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ext_strobe),
    .level_o (strobe_level_unused),
    .rise_o  (strobe_rise)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_eot_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ext_eot),
    .level_o (eot_level),
    .rise_o  (eot_rise_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      byte_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      byte_q    <= byte_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    byte_d    = byte_q;
    overrun_d = overrun_q;
    // A strobe outside WAIT_BYTE is dropped and flagged
    if (strobe_rise && state_q != S_WAIT_BYTE) begin
      overrun_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (read_ecall) begin
          count_d   = '0;
          overrun_d = strobe_rise;
          state_d   = (read_ecall_len == '0) ? S_DONE
                                             : S_WAIT_BYTE;
        end
      end
      S_WAIT_BYTE: begin
        if (!read_ecall) begin
          state_d = S_IDLE;
        end else if (strobe_rise) begin
          byte_d  = ext_data;
          state_d = S_WRITE;
        end else if (eot_level) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        if (count_d == read_ecall_len) begin
          state_d = S_DONE;
        end else if (!read_ecall) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_BYTE;
        end
      end
      S_DONE: begin
        if (!read_ecall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign read_ecall_finished = (state_q == S_IDLE) ||
                               (state_q == S_DONE);
  assign ext_ready     = (state_q == S_WAIT_BYTE);
  assign mem_busy      = (state_q == S_WAIT_BYTE) ||
                         (state_q == S_WRITE);
  assign mem_write_en  = (state_q == S_WRITE);
  assign read_ecall_count = count_q;
  assign overrun       = overrun_q;
  assign mem_address   = read_ecall_address + count_q;
  assign mem_data      = {{(BIT_WIDTH-8){1'b0}}, byte_q};
  assign mem_storetype = STORE_BYTE;

endmodule

// File: tb/tb_read_ecall_receiver.sv
// Randomized scenario bench for read_ecall_receiver against
// a transfer-level model of expected memory writes.
module tb_read_ecall_receiver;
  import read_ecall_receiver_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read_ecall = 1'b0;
  logic [31:0] read_ecall_address = '0;
  logic [31:0] read_ecall_len = '0;
  logic        read_ecall_finished;
  logic [31:0] read_ecall_count;
  logic [7:0]  ext_data = '0;
  logic        ext_strobe = 1'b0;
  logic        ext_eot = 1'b0;
  logic        ext_ready;
  logic        overrun;
  logic        mem_busy;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic [3:0]  mem_storetype;

  int checks = 0;
  int failures = 0;
  logic [63:0] wq[$];
  logic [7:0]  tx_bytes [16];

  read_ecall_receiver #(.SYNC_STAGES(SYNC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .read_ecall          (read_ecall),
    .read_ecall_address  (read_ecall_address),
    .read_ecall_len      (read_ecall_len),
    .read_ecall_finished (read_ecall_finished),
    .read_ecall_count    (read_ecall_count),
    .ext_data            (ext_data),
    .ext_strobe          (ext_strobe),
    .ext_eot             (ext_eot),
    .ext_ready           (ext_ready),
    .overrun             (overrun),
    .mem_busy            (mem_busy),
    .mem_write_en        (mem_write_en),
    .mem_address         (mem_address),
    .mem_data            (mem_data),
    .mem_storetype       (mem_storetype)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write_en === 1'b1) wq.push_back({mem_address, mem_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (ext_ready !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= TMO) begin
      failures++;
      $display("FAIL send_ready_wait got=timeout want=ready");
    end
    ext_data = b;
    repeat (SYNC + 2) @(negedge clk);
    ext_strobe = 1'b1;
    t = 0;
    while (ext_ready !== 1'b0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= TMO) begin
      failures++;
      $display("FAIL send_ack_wait got=timeout want=ready_low");
    end
    ext_strobe = 1'b0;
  endtask

  task automatic run_transfer(input logic [31:0] addr,
                              input logic [31:0] len,
                              input int nsend,
                              input string name);
    int n;
    int t;
    logic [63:0] exp;
    n = (32'(nsend) < len) ? nsend : int'(len);
    wq.delete();
    @(negedge clk);
    read_ecall_address = addr;
    read_ecall_len     = len;
    read_ecall         = 1'b1;
    @(negedge clk);
    checks++;
    if (ext_ready !== 1'(len != 0) ||
        read_ecall_finished !== 1'(len == 0) ||
        read_ecall_count !== 32'd0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL %s_start got rdy=%b fin=%b cnt=%0d ovr=%b want rdy=%b fin=%b cnt=0 ovr=0",
               name, ext_ready, read_ecall_finished,
               read_ecall_count, overrun, len != 0, len == 0);
    end
    checks++;
    if (mem_storetype !== STORE_BYTE) begin
      failures++;
      $display("FAIL %s_storetype got=%h want=%h",
               name, mem_storetype, STORE_BYTE);
    end
    for (int i = 0; i < n; i++) send_byte(tx_bytes[i]);
    if (32'(n) < len) begin
      @(negedge clk);
      ext_eot = 1'b1;
    end
    t = 0;
    while (read_ecall_finished !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    ext_eot = 1'b0;
    checks++;
    if (t >= TMO) begin
      failures++;
      $display("FAIL %s_finish got=timeout want=finished", name);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ext_ready !== 1'b0 || mem_busy !== 1'b0 ||
        read_ecall_finished !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_hold got rdy=%b busy=%b fin=%b want 0 0 1",
               name, ext_ready, mem_busy, read_ecall_finished);
    end
    checks++;
    if (read_ecall_count !== 32'(n)) begin
      failures++;
      $display("FAIL %s_count got=%0d want=%0d",
               name, read_ecall_count, n);
    end
    checks++;
    if (wq.size() != n) begin
      failures++;
      $display("FAIL %s_nwrites got=%0d want=%0d",
               name, wq.size(), n);
    end
    for (int i = 0; i < n && i < wq.size(); i++) begin
      exp = {addr + 32'(i), 24'h0, tx_bytes[i]};
      checks++;
      if (wq[i] !== exp) begin
        failures++;
        $display("FAIL %s_write%0d got=%h want=%h",
                 name, i, wq[i], exp);
      end
    end
    read_ecall = 1'b0;
    @(negedge clk);
    checks++;
    if (read_ecall_finished !== 1'b1 || mem_busy !== 1'b0 ||
        read_ecall_count !== 32'(n)) begin
      failures++;
      $display("FAIL %s_release got fin=%b busy=%b cnt=%0d want 1 0 %0d",
               name, read_ecall_finished, mem_busy,
               read_ecall_count, n);
    end
  endtask

  task automatic test_reset();
    read_ecall_address = 32'h0000_0300;
    repeat (2) @(negedge clk);
    checks++;
    if (read_ecall_finished !== 1'b1 || ext_ready !== 1'b0 ||
        mem_busy !== 1'b0 || mem_write_en !== 1'b0 ||
        overrun !== 1'b0 || read_ecall_count !== 32'd0 ||
        mem_data !== 32'd0 || mem_address !== 32'h300) begin
      failures++;
      $display("FAIL reset_state got fin=%b rdy=%b busy=%b we=%b ovr=%b cnt=%0d data=%h addr=%h",
               read_ecall_finished, ext_ready, mem_busy,
               mem_write_en, overrun, read_ecall_count,
               mem_data, mem_address);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal();
    tx_bytes[0] = 8'h41;
    tx_bytes[1] = 8'h42;
    tx_bytes[2] = 8'h43;
    run_transfer(32'h100, 32'd3, 3, "normal");
  endtask

  task automatic test_eot();
    tx_bytes[0] = 8'hA5;
    tx_bytes[1] = 8'h5A;
    run_transfer(32'h180, 32'd8, 2, "eot");
  endtask

  task automatic test_zero_len();
    run_transfer(32'h1C0, 32'd0, 0, "zero");
  endtask

  task automatic test_overrun();
    wq.delete();
    @(negedge clk);
    read_ecall_len = 32'd0;
    read_ecall     = 1'b1;
    @(negedge clk);
    ext_data   = 8'h99;
    ext_strobe = 1'b1;
    repeat (3) @(negedge clk);
    ext_strobe = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || wq.size() != 0 ||
        ext_ready !== 1'b0) begin
      failures++;
      $display("FAIL overrun_set got ovr=%b writes=%0d rdy=%b want 1 0 0",
               overrun, wq.size(), ext_ready);
    end
    read_ecall = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got=%b want=1", overrun);
    end
    tx_bytes[0] = 8'h12;
    tx_bytes[1] = 8'h34;
    run_transfer(32'h400, 32'd2, 2, "post_overrun");
  endtask

  task automatic test_reset_mid();
    wq.delete();
    @(negedge clk);
    read_ecall_address = 32'h200;
    read_ecall_len     = 32'd4;
    read_ecall         = 1'b1;
    @(negedge clk);
    send_byte(8'h11);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (read_ecall_finished !== 1'b1 || ext_ready !== 1'b0 ||
        mem_busy !== 1'b0 || mem_write_en !== 1'b0 ||
        read_ecall_count !== 32'd0 || mem_data !== 32'd0 ||
        mem_address !== 32'h200) begin
      failures++;
      $display("FAIL rstmid_outputs got fin=%b rdy=%b busy=%b we=%b cnt=%0d data=%h addr=%h",
               read_ecall_finished, ext_ready, mem_busy,
               mem_write_en, read_ecall_count, mem_data,
               mem_address);
    end
    ext_data   = 8'h22;
    ext_strobe = 1'b1;
    repeat (4) @(negedge clk);
    ext_strobe = 1'b0;
    repeat (4) @(negedge clk);
    read_ecall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wq.size() != 1 || wq[0] !== {32'h200, 32'h11}) begin
      failures++;
      $display("FAIL rstmid_writes got n=%0d w0=%h want n=1 w0=%h",
               wq.size(), (wq.size() > 0) ? wq[0] : 64'h0,
               {32'h200, 32'h11});
    end
    tx_bytes[0] = 8'h66;
    run_transfer(32'h200, 32'd1, 1, "post_reset");
  endtask

  task automatic test_abort();
    wq.delete();
    @(negedge clk);
    read_ecall_address = 32'h500;
    read_ecall_len     = 32'd4;
    read_ecall         = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ext_ready !== 1'b1 || mem_busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_wait got rdy=%b busy=%b want 1 1",
               ext_ready, mem_busy);
    end
    read_ecall = 1'b0;
    @(negedge clk);
    checks++;
    if (read_ecall_finished !== 1'b1 || mem_busy !== 1'b0 ||
        ext_ready !== 1'b0 || wq.size() != 0) begin
      failures++;
      $display("FAIL abort_idle got fin=%b busy=%b rdy=%b writes=%0d want 1 0 0 0",
               read_ecall_finished, mem_busy, ext_ready, wq.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int len;
    int ns;
    for (int it = 0; it < 8; it++) begin
      addr = $urandom;
      len  = $urandom_range(1, 6);
      ns   = $urandom_range(0, len);
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
      run_transfer(addr, 32'(len), ns, "random");
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_eot();
    test_zero_len();
    test_overrun();
    test_reset_mid();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
